// File: rtl/param_stack_pkg.sv
// Shared definitions for the parametrised operand stack.
// Holds the parameter defaults and the operation encoding that the
// ALU control can reuse. Optional error flags: STACK_ERR_FLAGS_EN.
package param_stack_pkg;

  // Default data word width and stack depth
  localparam int WORD_WIDTH = 8;
  localparam int STACK_SIZE = 8;

  // Per-cycle operation decode; bit 1 = push, bit 0 = pop
  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  // Map the raw push/pop request pair onto an operation code
  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/param_stack_occupancy.sv
// Occupancy tracking for param_stack: saturating entry count,
// empty/full decode and, when STACK_ERR_FLAGS_EN is defined, the
// sticky overflow/underflow flags.
module stack_occupancy
  import param_stack_pkg::*;
#(
  parameter int DEPTH = STACK_SIZE,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  stack_op_e     op_i,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);

  logic [CW-1:0] count_q, count_d;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == COUNT_MAX);
  assign count_o = count_q;

  // Next count: saturates at 0 and DEPTH, replace on empty acts as push
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    unique case (op_i)
      OP_PUSH:    if (!full_o)  count_d = count_q + COUNT_ONE;
      OP_POP:     if (!empty_o) count_d = count_q - COUNT_ONE;
      OP_REPLACE: if (empty_o)  count_d = COUNT_ONE;
      default:    count_d = count_q;
    endcase
  end

  // Count register with synchronous reset
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

`ifdef STACK_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: set on push-while-full / pop-while-empty only
  always_comb begin
    overflow_d  = overflow_q  | ((op_i == OP_PUSH) && full_o);
    underflow_d = underflow_q | ((op_i == OP_POP)  && empty_o);
  end

  // Flag registers, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: rtl/param_stack.sv
// Parametrised operand stack with second-entry read port, occupancy
// count, empty/full flags and a combined push+pop "replace top".
// Optional sticky overflow/underflow flags: define STACK_ERR_FLAGS_EN.
module param_stack
  import param_stack_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = STACK_SIZE,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] next,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  stack_op_e op;
  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];

  assign op = decode_op(push, pop);

  stack_occupancy #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_occupancy (
    .clock       (clock),
    .reset       (reset),
    .op_i        (op),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  // Next array contents: shift down on push, shift up on pop, overwrite on replace
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries_d[i] = entries_q[i];
    unique case (op)
      OP_PUSH: begin
        // Bottom entry falls off when full
        entries_d[0] = write_data;
        for (int i = 1; i < DEPTH; i++) entries_d[i] = entries_q[i-1];
      end
      OP_POP: begin
        if (!empty) begin
          for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = entries_q[i+1];
          entries_d[DEPTH-1] = '0;
        end
      end
      OP_REPLACE: entries_d[0] = write_data;
      default: ;
    endcase
  end

  // Storage array register
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the array is reset because invalid entries must read as 0 on top/next.
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

  // Invalid entries always hold 0, so direct reads satisfy the zero-when-invalid rule
  assign top  = entries_q[0];
  assign next = entries_q[1];

endmodule
